sc_adder_tree_counter: RTL and testbench

Parametrised N-input stochastic scaled adder built as a pipelined balanced tree of 2:1 mux adders. Select streams come from an internal LFSR, so no external select inputs are needed. An integrated window counter converts the output bitstream to a binary count. It replaces hand-wired adder chains in the stochastic datapath and feeds binary consumers directly.

---
 rtl/sc_pkg.sv | 22 ++
 rtl/sc_adder.sv | 14 +
 rtl/sc_lfsr16.sv | 29 ++
 rtl/sc_adder_tree_counter.sv | 120 ++++++++++++
 tb/tb_sc_adder_tree_counter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing datapath.
//   LFSR_TAPS         : Fibonacci feedback mask for x^16+x^14+x^13+x^11+1
//   LFSR_DEFAULT_SEED : default nonzero reset value for the LFSR
//   sc_clog2          : ceiling log2, usable in parameter expressions
package sc_pkg;

  localparam int          LFSR_WIDTH        = 16;
  // Exponents 16,14,13,11 map to state bits 0,2,3,5 of a right-shifting register.
  localparam logic [15:0] LFSR_TAPS         = 16'h002D;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Smallest r with 2^r >= value; sc_clog2(1) == 0.
  function automatic int sc_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_adder.sv
// Stochastic scaled adder cell: a 2:1 mux.
//   x, y : input bitstreams
//   sel  : select bitstream (0 picks x, 1 picks y)
//   z    : output bitstream, P(z) = (P(x) + P(y)) / 2 for an unbiased sel
module sc_adder (
  input  logic x,
  input  logic y,
  input  logic sel,
  output logic z
);

  assign z = sel ? y : x;

endmodule

// File: rtl/sc_lfsr16.sv
// 16-bit Fibonacci LFSR used as the select-stream source.
//   clk, rst : clock and synchronous active-high reset
//   en       : advance one step per enabled cycle, hold otherwise
//   seed     : reset value, must be nonzero
//   state    : current register contents
module sc_lfsr16
  import sc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  logic feedback;

  assign feedback = ^(state & LFSR_TAPS);

  // New bit enters at the MSB, so bit k of today is bit k+1 of yesterday.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed;
    end else if (en) begin
      state <= {feedback, state[15:1]};
    end
  end

endmodule

// File: rtl/sc_adder_tree_counter.sv
// Pipelined balanced tree of stochastic mux adders with an integrated
// window counter that turns the output bitstream into a binary count.
//   clk, rst    : clock and synchronous active-high reset
//   en          : advance enable, the whole block holds when low
//   inputs      : N input bitstream bits
//   sum         : scaled-sum bitstream, P(sum) = sum(p_i) / 2^clog2(N)
//   count       : ones counted in the last completed window of STREAM_LEN bits
//   count_valid : one-cycle pulse on the edge that count updates
module sc_adder_tree_counter
  import sc_pkg::*;
#(
  parameter  int          N          = 8,
  parameter  int          STREAM_LEN = 256,
  parameter  logic [15:0] SEED       = LFSR_DEFAULT_SEED,
  localparam int          D          = sc_clog2(N),
  localparam int          P          = 1 << D,
  localparam int          CW         = sc_clog2(STREAM_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  inputs,
  output logic          sum,
  output logic [CW-1:0] count,
  output logic          count_valid
);

  // pos must hold 0..STREAM_LEN-1 and still be at least one bit wide.
  localparam int PW = (sc_clog2(STREAM_LEN) < 1) ? 1 : sc_clog2(STREAM_LEN);

  logic [15:0]         lfsr_state;
  logic [D:0][P-1:0]   tree;
  logic [D-1:0]        vld;
  logic [CW-1:0]       acc;
  logic [PW-1:0]       pos;
  logic                unused_lfsr;
  logic                unused_tree;

  sc_lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .seed  (SEED),
    .state (lfsr_state)
  );

  // Leaves beyond N are tied to 0, which is why the scale is 1/P rather than 1/N.
  assign tree[0] = P'(inputs);

  // Level k reduces tree[k] into tree[k+1]; slots past the active width stay 0.
  for (genvar k = 0; k < D; k++) begin : g_level
    localparam int W = P >> (k + 1);
    for (genvar j = 0; j < P; j++) begin : g_node
      if (j < W) begin : g_active
        logic mux_out;
        logic node_q;

        sc_adder u_add (
          .x   (tree[k][2*j]),
          .y   (tree[k][2*j+1]),
          .sel (lfsr_state[k]),
          .z   (mux_out)
        );

        always_ff @(posedge clk) begin
          if (rst) begin
            node_q <= 1'b0;
          end else if (en) begin
            node_q <= mux_out;
          end
        end

        assign tree[k+1][j] = node_q;
      end else begin : g_pad
        assign tree[k+1][j] = 1'b0;
      end
    end
  end

  assign sum = tree[D][0];

  // Only the low D LFSR bits and the root of the tree are consumed.
  assign unused_lfsr = ^lfsr_state;
  assign unused_tree = ^tree;

  // Shifts in a 1 per enabled cycle so vld[D-1] marks the first bit that has
  // travelled the full tree since reset; priming zeros are never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else if (en) begin
      vld <= (vld << 1) | D'(1);
    end
  end

  // The closing bit of a window goes straight into count, so nothing is
  // lost or counted twice when acc restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      pos         <= '0;
      count       <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (en && vld[D-1]) begin
        if (pos == PW'(STREAM_LEN - 1)) begin
          count       <= acc + CW'(sum);
          count_valid <= 1'b1;
          acc         <= '0;
          pos         <= '0;
        end else begin
          acc <= acc + CW'(sum);
          pos <= pos + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sc_adder_tree_counter.sv
// Self-checking bench for sc_adder_tree_counter (N=8 and N=5, STREAM_LEN=256).
module tb_sc_adder_tree_counter;

  localparam int L = 256;
  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] inputs = '0;
  logic [4:0] inputs5 = '0;
  logic       sum, sum5, count_valid, cv5;
  logic [8:0] count, count5;

  int passes = 0;
  int total = 0;
  int en_cycles = 0;
  int obs_n, obs5_n, bad_pulse, hold_err;
  int obs_count [8];
  int obs_at [8];
  int obs5_count [8];
  int obs5_at [8];
  logic prev_sum;
  logic [15:0] sst [2048];

  always #5 clk = ~clk;

  sc_adder_tree_counter #(.N(8), .STREAM_LEN(L), .SEED(16'hACE1)) u_dut (
    .clk(clk), .rst(rst), .en(en), .inputs(inputs),
    .sum(sum), .count(count), .count_valid(count_valid)
  );

  sc_adder_tree_counter #(.N(5), .STREAM_LEN(L), .SEED(16'hACE1)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .inputs(inputs5),
    .sum(sum5), .count(count5), .count_valid(cv5)
  );

  // Reference: the root bit after enabled edge e picks leaf index whose bit k
  // is bit k of the LFSR state after e-D+k enabled edges.
  function automatic int model_count(input logic [7:0] leaves, input int w);
    int c, e, idx;
    c = 0;
    for (int i = 0; i < L; i++) begin
      e = D + w * L + i;
      idx = 0;
      for (int k = 0; k < D; k++) idx = idx | (int'(sst[e - D + k][k]) << k);
      c = c + int'(leaves[idx]);
    end
    return c;
  endfunction

  task automatic step(input bit en_v);
    en = en_v;
    @(posedge clk);
    @(negedge clk);
    if (en_v) en_cycles++;
    if (count_valid === 1'b1) begin
      if (!en_v) bad_pulse++;
      else if (obs_n < 8) begin
        obs_count[obs_n] = int'(count);
        obs_at[obs_n] = en_cycles;
        obs_n++;
      end
    end
    if (cv5 === 1'b1 && obs5_n < 8) begin
      obs5_count[obs5_n] = int'(count5);
      obs5_at[obs5_n] = en_cycles;
      obs5_n++;
    end
    if (!en_v && !rst && sum !== prev_sum) hold_err++;
    prev_sum = sum;
  endtask

  task automatic do_reset(input bit en_v);
    rst = 1'b1;
    step(en_v);
    rst = 1'b0;
    en_cycles = 0;
    obs_n = 0;
    obs5_n = 0;
    bad_pulse = 0;
    hold_err = 0;
    prev_sum = sum;
  endtask

  task automatic run_to(input int target, input bit rand_en);
    int guard;
    guard = 0;
    while (en_cycles < target && guard < 20000) begin
      step(rand_en ? bit'($urandom_range(0, 1)) : 1'b1);
      guard++;
    end
  endtask

  task automatic test_reset;
    inputs = 8'hFF;
    inputs5 = 5'h1F;
    do_reset(1'b1);
    total++; if (sum !== 1'b0) $display("[TB] FAIL reset_sum got %b want 0", sum); else passes++;
    total++; if (count !== 9'd0) $display("[TB] FAIL reset_count got %0d want 0", count); else passes++;
    total++; if (count_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", count_valid); else passes++;
    total++; if (count5 !== 9'd0) $display("[TB] FAIL reset_count5 got %0d want 0", count5); else passes++;
  endtask

  task automatic test_all_ones;
    int sum_err;
    inputs = 8'hFF;
    do_reset(1'b0);
    step(1'b1);
    total++; if (sum !== 1'b0) $display("[TB] FAIL ones_prime1 got %b want 0", sum); else passes++;
    step(1'b1);
    total++; if (sum !== 1'b0) $display("[TB] FAIL ones_prime2 got %b want 0", sum); else passes++;
    step(1'b1);
    total++; if (sum !== 1'b1) $display("[TB] FAIL ones_first got %b want 1", sum); else passes++;
    sum_err = 0;
    while (en_cycles < 2 * L + D && en_cycles < 2000) begin
      step(1'b1);
      if (sum !== 1'b1) sum_err++;
    end
    total++; if (sum_err != 0) $display("[TB] FAIL ones_steady got %0d zero bits want 0", sum_err); else passes++;
    total++; if (obs_n != 2) $display("[TB] FAIL ones_pulses got %0d want 2", obs_n); else passes++;
    total++; if (obs_at[0] != 259) $display("[TB] FAIL ones_first_at got %0d want 259", obs_at[0]); else passes++;
    total++; if (obs_count[0] != 256) $display("[TB] FAIL ones_count0 got %0d want 256", obs_count[0]); else passes++;
    total++; if (obs_at[1] != 515) $display("[TB] FAIL ones_second_at got %0d want 515", obs_at[1]); else passes++;
    total++; if (obs_count[1] != 256) $display("[TB] FAIL ones_count1 got %0d want 256", obs_count[1]); else passes++;
    step(1'b1);
    total++; if (count !== 9'd256 || count_valid !== 1'b0)
      $display("[TB] FAIL ones_hold got %0d/%b want 256/0", count, count_valid); else passes++;
  endtask

  task automatic test_all_zeros;
    int sum_err;
    inputs = 8'h00;
    do_reset(1'b0);
    sum_err = 0;
    while (en_cycles < 2 * L + D && en_cycles < 2000) begin
      step(1'b1);
      if (sum !== 1'b0) sum_err++;
    end
    total++; if (sum_err != 0) $display("[TB] FAIL zeros_sum got %0d one bits want 0", sum_err); else passes++;
    total++; if (obs_n != 2) $display("[TB] FAIL zeros_pulses got %0d want 2", obs_n); else passes++;
    total++; if (obs_count[0] != 0 || obs_count[1] != 0)
      $display("[TB] FAIL zeros_count got %0d,%0d want 0,0", obs_count[0], obs_count[1]); else passes++;
  endtask

  task automatic test_single_input;
    int exp_c;
    inputs = 8'h01;
    do_reset(1'b0);
    run_to(2 * L + D, 1'b0);
    total++; if (obs_n != 2) $display("[TB] FAIL single_pulses got %0d want 2", obs_n); else passes++;
    for (int w = 0; w < 2; w++) begin
      exp_c = model_count(8'h01, w);
      total++; if (obs_count[w] != exp_c)
        $display("[TB] FAIL single_model w%0d got %0d want %0d", w, obs_count[w], exp_c); else passes++;
      total++; if (obs_count[w] < 20 || obs_count[w] > 44)
        $display("[TB] FAIL single_range w%0d got %0d want 20..44", w, obs_count[w]); else passes++;
    end
  endtask

  task automatic test_n5_scaling;
    int exp_c;
    inputs = 8'h00;
    inputs5 = 5'h1F;
    do_reset(1'b0);
    run_to(2 * L + D, 1'b0);
    total++; if (obs5_n != 2) $display("[TB] FAIL n5_pulses got %0d want 2", obs5_n); else passes++;
    total++; if (obs5_at[0] != 259) $display("[TB] FAIL n5_first_at got %0d want 259", obs5_at[0]); else passes++;
    for (int w = 0; w < 2; w++) begin
      exp_c = model_count(8'h1F, w);
      total++; if (obs5_count[w] != exp_c)
        $display("[TB] FAIL n5_model w%0d got %0d want %0d", w, obs5_count[w], exp_c); else passes++;
      total++; if (obs5_count[w] < 136 || obs5_count[w] > 184)
        $display("[TB] FAIL n5_range w%0d got %0d want 136..184", w, obs5_count[w]); else passes++;
    end
  endtask

  task automatic test_random_en;
    int exp_c;
    inputs = 8'h5A;
    do_reset(1'b0);
    run_to(2 * L + D, 1'b1);
    total++; if (en_cycles != 515) $display("[TB] FAIL rand_budget got %0d want 515", en_cycles); else passes++;
    total++; if (bad_pulse != 0) $display("[TB] FAIL rand_pulse_while_idle got %0d want 0", bad_pulse); else passes++;
    total++; if (hold_err != 0) $display("[TB] FAIL rand_sum_hold got %0d changes want 0", hold_err); else passes++;
    total++; if (obs_n != 2 || obs_at[0] != 259 || obs_at[1] != 515)
      $display("[TB] FAIL rand_timing got n=%0d at %0d,%0d want 2 at 259,515", obs_n, obs_at[0], obs_at[1]); else passes++;
    for (int w = 0; w < 2; w++) begin
      exp_c = model_count(8'h5A, w);
      total++; if (obs_count[w] != exp_c)
        $display("[TB] FAIL rand_model w%0d got %0d want %0d", w, obs_count[w], exp_c); else passes++;
    end
  endtask

  task automatic test_mid_reset;
    int exp_c;
    inputs = 8'hC3;
    do_reset(1'b0);
    run_to(L + D + 100, 1'b0);
    exp_c = model_count(8'hC3, 0);
    total++; if (obs_n != 1 || obs_count[0] != exp_c)
      $display("[TB] FAIL midrst_pre got n=%0d c=%0d want 1 c=%0d", obs_n, obs_count[0], exp_c); else passes++;
    do_reset(1'b1);
    total++; if (sum !== 1'b0 || count !== 9'd0 || count_valid !== 1'b0)
      $display("[TB] FAIL midrst_clear got %b/%0d/%b want 0/0/0", sum, count, count_valid); else passes++;
    run_to(L + D, 1'b0);
    total++; if (obs_n != 1 || obs_at[0] != 259)
      $display("[TB] FAIL midrst_timing got n=%0d at %0d want 1 at 259", obs_n, obs_at[0]); else passes++;
    total++; if (obs_count[0] != exp_c)
      $display("[TB] FAIL midrst_count got %0d want %0d", obs_count[0], exp_c); else passes++;
  endtask

  initial begin
    // Golden LFSR: feedback from bits 0,2,3,5 (x^16+x^14+x^13+x^11+1), shift right.
    sst[0] = 16'hACE1;
    for (int i = 1; i < 2048; i++)
      sst[i] = {sst[i-1][0] ^ sst[i-1][2] ^ sst[i-1][3] ^ sst[i-1][5], sst[i-1][15:1]};
    @(negedge clk);
    test_reset();
    test_all_ones();
    test_all_zeros();
    test_single_input();
    test_n5_scaling();
    test_random_en();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
